// File: rtl/img_pass_ctrl_if.sv
// Control and BRAM-side signal bundle of the multi-pass image sequencer.
// The sequencer uses the slave modport; whoever issues runs uses the master modport.
interface img_pass_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int SEL_W  = 2
);
    logic              start;
    logic              abort;
    logic [SEL_W-1:0]  mode;
    logic [2:0]        num_pass;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              ena;
    logic              enb;
    logic              wea1;
    logic              wea2;
    logic              rd_bank;
    logic [SEL_W-1:0]  sel;
    logic [2:0]        pass_idx;
    logic              busy;
    logic              complete;

    modport master (
        output start, abort, mode, num_pass,
        input  rd_addr, wr_addr, ena, enb, wea1, wea2, rd_bank, sel, pass_idx, busy, complete
    );

    modport slave (
        input  start, abort, mode, num_pass,
        output rd_addr, wr_addr, ena, enb, wea1, wea2, rd_bank, sel, pass_idx, busy, complete
    );
endinterface

// File: rtl/img_pass_ctrl.sv
// Multi-pass frame sequencer ping-ponging two BRAM banks through the filter pipeline.
// Reads start the cycle after start; writes trail reads by PIPE_LAT cycles; no backpressure.
module img_pass_ctrl #(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int ADDR_W   = 12,
    parameter int PIPE_LAT = 3,
    parameter int PASS_MAX = 4,
    parameter int SEL_W    = 2
) (
    input  logic           clk,
    input  logic           rst,
    img_pass_ctrl_if.slave bus
);
    localparam int                N    = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
    localparam logic [2:0]        PMAX = 3'(PASS_MAX);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]          state;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [PIPE_LAT-1:0] wv_sr;
    logic [2:0]          pass_q;
    logic [2:0]          passes_q;
    logic [SEL_W-1:0]    sel_q;
    logic [2:0]          np_clamped;
    logic                rd_en;
    logic                wv;
    logic                wr_done;
    logic                last_pass;

    always_comb begin
        np_clamped = bus.num_pass;
        if (bus.num_pass == 3'd0)
            np_clamped = 3'd1;
        else if (bus.num_pass > PMAX)
            np_clamped = PMAX;
    end

    assign rd_en     = (state == S_READ);
    assign wv        = wv_sr[PIPE_LAT-1];
    assign wr_done   = wv && (wr_addr_q == LAST);
    assign last_pass = (pass_q == passes_q - 3'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wv_sr     <= '0;
            pass_q    <= '0;
            passes_q  <= '0;
            sel_q     <= '0;
        end else begin
            // The write-valid pipe shadows the filter latency regardless of state.
            wv_sr[0] <= rd_en;
            for (int i = 1; i < PIPE_LAT; i++)
                wv_sr[i] <= wv_sr[i-1];
            if (wv && (wr_addr_q != LAST))
                wr_addr_q <= wr_addr_q + 1'b1;

            if ((state != S_IDLE) && bus.abort) begin
                state     <= S_IDLE;
                rd_addr_q <= '0;
                wr_addr_q <= '0;
                wv_sr     <= '0;
                pass_q    <= '0;
            end else begin
                case (state)
                    S_IDLE: if (bus.start) begin
                        sel_q     <= bus.mode;
                        passes_q  <= np_clamped;
                        pass_q    <= '0;
                        rd_addr_q <= '0;
                        wr_addr_q <= '0;
                        state     <= S_READ;
                    end
                    S_READ: begin
                        if (rd_addr_q == LAST)
                            state <= S_DRAIN;
                        else
                            rd_addr_q <= rd_addr_q + 1'b1;
                    end
                    S_DRAIN: if (wr_done)
                        state <= last_pass ? S_DONE : S_NEXT;
                    S_NEXT: begin
                        pass_q    <= pass_q + 3'd1;
                        rd_addr_q <= '0;
                        wr_addr_q <= '0;
                        state     <= S_READ;
                    end
                    S_DONE: begin
                        pass_q    <= '0;
                        rd_addr_q <= '0;
                        wr_addr_q <= '0;
                        state     <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Even passes read bank 0 and write bank 1; odd passes the reverse.
    assign bus.rd_addr  = rd_addr_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.ena      = rd_en;
    assign bus.enb      = wv;
    assign bus.wea1     = wv & pass_q[0];
    assign bus.wea2     = wv & ~pass_q[0];
    assign bus.rd_bank  = pass_q[0];
    assign bus.sel      = sel_q;
    assign bus.pass_idx = pass_q;
    assign bus.busy     = (state != S_IDLE);
    assign bus.complete = (state == S_DONE);
endmodule

// File: tb/tb_img_pass_ctrl.sv
// Directed table-driven bench for img_pass_ctrl on a 4x4 frame with a 2-deep pipeline.
module tb_img_pass_ctrl;
    localparam int N  = 16;
    localparam int PL = 2;
    localparam int L  = N + PL + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    img_pass_ctrl_if #(.ADDR_W(12), .SEL_W(2)) bus ();

    img_pass_ctrl #(
        .IMG_W(4), .IMG_H(4), .ADDR_W(12), .PIPE_LAT(PL), .PASS_MAX(4), .SEL_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string       name;
        int          cyc;
        logic        start;
        logic        abort;
        logic [1:0]  mode;
        logic [2:0]  num_pass;
        logic        ena, enb, wea1, wea2, rd_bank, busy, complete;
        logic [11:0] rd_addr, wr_addr;
        logic [1:0]  sel;
        logic [2:0]  pass_idx;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t blank(string nm, int c, logic [1:0] s);
        vec_t r;
        r.name = nm; r.cyc = c;
        r.start = 0; r.abort = 0; r.mode = 0; r.num_pass = 0;
        r.ena = 0; r.enb = 0; r.wea1 = 0; r.wea2 = 0; r.rd_bank = 0;
        r.busy = 0; r.complete = 0; r.rd_addr = 0; r.wr_addr = 0;
        r.sel = s; r.pass_idx = 0;
        return r;
    endfunction

    task automatic add_idle(string nm, int n, logic [1:0] s);
        for (int c = 0; c < n; c++) tbl.push_back(blank(nm, c, s));
    endtask

    // One run started in cycle 0; expectations come from the cycle formula of the frame timing.
    task automatic add_run(string nm, int passes, logic [1:0] md, logic [2:0] np,
                           logic [1:0] prev_sel, int restart_at, int abort_at, bit ab0, int lim);
        int   ncyc;
        int   p, o;
        vec_t r;
        ncyc = (abort_at >= 0) ? abort_at + 3 : passes * L + 2;
        if (lim > 0 && lim < ncyc) ncyc = lim;
        for (int c = 0; c < ncyc; c++) begin
            r = blank(nm, c, (c == 0) ? prev_sel : md);
            r.start    = (c == 0) || (c == restart_at);
            r.abort    = (c == abort_at) || (ab0 && c == 0);
            r.mode     = (c == 0) ? md : ~md;
            r.num_pass = (c == 0) ? np : 3'd5;
            if (c >= 1 && !(abort_at >= 0 && c > abort_at)) begin
                p = (c - 1) / L;
                o = (c - 1) % L;
                if (p < passes) begin
                    r.busy     = 1;
                    r.pass_idx = 3'(p);
                    r.rd_bank  = p[0];
                    if (o < N) begin
                        r.ena = 1; r.rd_addr = 12'(o);
                    end
                    if (o >= PL && o < N + PL) begin
                        r.enb = 1; r.wea1 = p[0]; r.wea2 = ~p[0]; r.wr_addr = 12'(o - PL);
                    end
                    if (o == N + PL && p == passes - 1) r.complete = 1;
                end
            end
            tbl.push_back(r);
        end
    endtask

    task automatic check_vec(vec_t v);
        logic [11:0] act, exp;
        bit bad;
        act = {bus.ena, bus.enb, bus.wea1, bus.wea2, bus.rd_bank, bus.busy, bus.complete, bus.sel, bus.pass_idx};
        exp = {v.ena, v.enb, v.wea1, v.wea2, v.rd_bank, v.busy, v.complete, v.sel, v.pass_idx};
        bad = (act !== exp);
        if (v.ena && bus.rd_addr !== v.rd_addr) bad = 1;
        if (v.enb && bus.wr_addr !== v.wr_addr) bad = 1;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got flags=%b rd=%0d wr=%0d, want flags=%b rd=%0d wr=%0d",
                     v.name, v.cyc, act, bus.rd_addr, bus.wr_addr, exp, v.rd_addr, v.wr_addr);
        end
    endtask

    task automatic check_zero(string nm);
        logic [35:0] act;
        act = {bus.ena, bus.enb, bus.wea1, bus.wea2, bus.rd_bank, bus.busy, bus.complete,
               bus.sel, bus.pass_idx, bus.rd_addr, bus.wr_addr};
        vectors++;
        if (act !== 36'd0) begin
            miscompares++;
            $display("FAIL %s: got outputs=%h, want all zero", nm, act);
        end
    endtask

    task automatic apply_table();
        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            check_vec(tbl[i]);
            bus.start    = tbl[i].start;
            bus.abort    = tbl[i].abort;
            bus.mode     = tbl[i].mode;
            bus.num_pass = tbl[i].num_pass;
        end
        bus.start = 0;
        bus.abort = 0;
        tbl.delete();
    endtask

    initial begin
        bus.start = 0; bus.abort = 0; bus.mode = 0; bus.num_pass = 0;
        #1 rst = 1;
        #1 check_zero("t1_reset_noclk");
        repeat (2) @(posedge clk);
        #2 rst = 0;

        add_idle("t1_idle", 5, 2'd0);                             apply_table();
        add_run("t2_single", 1, 2'd2, 3'd1, 2'd0, -1, -1, 0, 0);  apply_table();
        add_run("t3_three", 3, 2'd1, 3'd3, 2'd2, -1, -1, 0, 0);   apply_table();
        add_run("t4_restart", 1, 2'd3, 3'd1, 2'd1, 8, -1, 0, 0);  apply_table();
        add_run("t4_np0", 1, 2'd0, 3'd0, 2'd3, -1, -1, 0, 0);     apply_table();
        add_run("t4_np7", 4, 2'd2, 3'd7, 2'd0, -1, -1, 0, 0);     apply_table();
        add_run("t5_abort", 1, 2'd1, 3'd1, 2'd2, -1, 10, 0, 0);   apply_table();
        add_run("t5_rerun", 1, 2'd2, 3'd1, 2'd1, -1, -1, 0, 0);   apply_table();
        add_run("abort_start_idle", 1, 2'd3, 3'd1, 2'd2, -1, -1, 1, 0); apply_table();

        add_run("t6_pre", 1, 2'd1, 3'd1, 2'd3, -1, -1, 0, 8);     apply_table();
        @(posedge clk);
        #3 rst = 1;
        #1 check_zero("t6_async_reset");
        @(posedge clk);
        #1 check_zero("t6_held");
        #2 rst = 0;
        add_run("t6_rerun", 1, 2'd2, 3'd1, 2'd0, -1, -1, 0, 0);   apply_table();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
